// File: rtl/mips_pipeline_pkg.sv
// rtl/mips_pipeline_pkg.sv - shared pipeline register-file constants and types
package mips_pipeline_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;
    localparam logic [REG_ADDR_W-1:0] REG_LINK = 5'd31;

    typedef enum logic [1:0] {
        RT   = 2'b00,
        RD   = 2'b01,
        LINK = 2'b10
    } regdst_t;

endpackage

// File: rtl/sb_counter.sv
// rtl/sb_counter.sv - per-register in-flight write counter with underflow clamp
module sb_counter #(
    parameter int CNT_W = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic dec_a,
    input  logic dec_b,
    output logic nonzero,
    output logic at_max,
    output logic underflow
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic [CNT_W+1:0] sum;

    // Net +1/-1/-1 applied in one step; two spare bits hold the sign and a carry.
    always_comb begin
        sum = {2'b00, count_q}
            + {{(CNT_W+1){1'b0}}, inc}
            - {{(CNT_W+1){1'b0}}, dec_a}
            - {{(CNT_W+1){1'b0}}, dec_b};
        underflow = sum[CNT_W+1];
        if (underflow)
            count_d = '0;
        else if (sum[CNT_W])
            count_d = CNT_MAX;
        else
            count_d = sum[CNT_W-1:0];
    end

    // Counter register; reset discards any in-flight state.
    always_ff @(posedge clk) begin
        if (reset)
            count_q <= '0;
        else
            count_q <= count_d;
    end

    assign nonzero = (count_q != '0);
    assign at_max  = (count_q == CNT_MAX);

endmodule

// File: rtl/reg_scoreboard.sv
// rtl/reg_scoreboard.sv - GPR write scoreboard holding ID on pending sources or saturated destinations
module reg_scoreboard
    import mips_pipeline_pkg::*;
#(
    parameter int CNT_W   = 2,
    parameter int STALL_W = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_uses_rs,
    input  logic                  id_uses_rt,
    input  logic                  id_writes,
    input  logic [REG_ADDR_W-1:0] id_dst,
    input  logic                  wb_valid,
    input  logic [REG_ADDR_W-1:0] wb_dst,
    input  logic                  kill_valid,
    input  logic [REG_ADDR_W-1:0] kill_dst,
    output logic                  stall,
    output logic                  issue,
    output logic [NUM_REGS-1:0]   busy_mask,
    output logic [STALL_W-1:0]    stall_count,
    output logic                  underflow
);

    logic [NUM_REGS-1:0] nonzero_v;
    logic [NUM_REGS-1:0] at_max_v;
    logic [NUM_REGS-1:0] uf_v;
    logic                hazard_rs;
    logic                hazard_rt;
    logic                sat;

    // r0 is hardwired zero, so it never has a counter.
    assign nonzero_v[0] = 1'b0;
    assign at_max_v[0]  = 1'b0;
    assign uf_v[0]      = 1'b0;

    for (genvar r = 1; r < NUM_REGS; r++) begin : g_cnt
        sb_counter #(.CNT_W(CNT_W)) u_cnt (
            .clk       (clk),
            .reset     (reset),
            .inc       (issue & id_writes & (id_dst == REG_ADDR_W'(r))),
            .dec_a     (wb_valid & (wb_dst == REG_ADDR_W'(r))),
            .dec_b     (kill_valid & (kill_dst == REG_ADDR_W'(r))),
            .nonzero   (nonzero_v[r]),
            .at_max    (at_max_v[r]),
            .underflow (uf_v[r])
        );
    end

    // Hazard detect against registered counts only: a retire this cycle clears next cycle.
    always_comb begin
        hazard_rs = id_uses_rs & (id_rs  != REG_ZERO) & nonzero_v[id_rs];
        hazard_rt = id_uses_rt & (id_rt  != REG_ZERO) & nonzero_v[id_rt];
        sat       = id_writes  & (id_dst != REG_ZERO) & at_max_v[id_dst];
        stall     = id_valid & (hazard_rs | hazard_rt | sat);
        issue     = id_valid & ~stall;
    end

    assign busy_mask = nonzero_v;

    // Free-running count of stalled cycles, wrapping.
    always_ff @(posedge clk) begin
        if (reset)
            stall_count <= '0;
        else if (stall)
            stall_count <= stall_count + 1'b1;
    end

    // Sticky error: any counter clamped at zero since reset.
    always_ff @(posedge clk) begin
        if (reset)
            underflow <= 1'b0;
        else if (|uf_v)
            underflow <= 1'b1;
    end

endmodule

// File: tb/tb_reg_scoreboard.sv
// tb/tb_reg_scoreboard.sv - directed self-checking bench for reg_scoreboard
module tb_reg_scoreboard;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        id_uses_rs;
    logic        id_uses_rt;
    logic        id_writes;
    logic [4:0]  id_dst;
    logic        wb_valid;
    logic [4:0]  wb_dst;
    logic        kill_valid;
    logic [4:0]  kill_dst;
    logic        stall;
    logic        issue;
    logic [31:0] busy_mask;
    logic [31:0] stall_count;
    logic        underflow;

    int tests;
    int fails;
    int exp_sc;

    reg_scoreboard dut (
        .clk         (clk),
        .reset       (reset),
        .id_valid    (id_valid),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_uses_rs  (id_uses_rs),
        .id_uses_rt  (id_uses_rt),
        .id_writes   (id_writes),
        .id_dst      (id_dst),
        .wb_valid    (wb_valid),
        .wb_dst      (wb_dst),
        .kill_valid  (kill_valid),
        .kill_dst    (kill_dst),
        .stall       (stall),
        .issue       (issue),
        .busy_mask   (busy_mask),
        .stall_count (stall_count),
        .underflow   (underflow)
    );

    always #5 clk = ~clk;

    task automatic clr_inputs();
        id_valid = 0; id_rs = 0; id_rt = 0; id_uses_rs = 0; id_uses_rt = 0;
        id_writes = 0; id_dst = 0; wb_valid = 0; wb_dst = 0; kill_valid = 0; kill_dst = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_writer(input logic [4:0] dst);
        clr_inputs();
        id_valid = 1; id_writes = 1; id_dst = dst;
        #1;
    endtask

    task automatic drive_wb(input logic [4:0] dst);
        clr_inputs();
        wb_valid = 1; wb_dst = dst;
        #1;
    endtask

    task automatic test_reset();
        clr_inputs();
        reset = 1;
        tick(); tick();
        reset = 0;
        #1;
        tests++; if (stall !== 1'b0) begin fails++; $display("FAIL reset_stall got=%b exp=0", stall); end
        tests++; if (issue !== 1'b0) begin fails++; $display("FAIL reset_issue got=%b exp=0", issue); end
        tests++; if (busy_mask !== 32'h0) begin fails++; $display("FAIL reset_busy got=%h exp=0", busy_mask); end
        tests++; if (stall_count !== 32'd0) begin fails++; $display("FAIL reset_stall_count got=%0d exp=0", stall_count); end
        tests++; if (underflow !== 1'b0) begin fails++; $display("FAIL reset_underflow got=%b exp=0", underflow); end
    endtask

    task automatic test_basic_issue();
        clr_inputs();
        id_valid = 1; id_rs = 3; id_uses_rs = 1;
        #1;
        tests++; if (stall !== 1'b0) begin fails++; $display("FAIL basic_stall got=%b exp=0", stall); end
        tests++; if (issue !== 1'b1) begin fails++; $display("FAIL basic_issue got=%b exp=1", issue); end
        tests++; if (busy_mask !== 32'h0) begin fails++; $display("FAIL basic_busy got=%h exp=0", busy_mask); end
        tick();
        clr_inputs();
    endtask

    task automatic test_raw_hazard();
        drive_writer(5);
        tests++; if (issue !== 1'b1) begin fails++; $display("FAIL raw_writer_issue got=%b exp=1", issue); end
        tick();
        for (int i = 0; i < 3; i++) begin
            clr_inputs();
            id_valid = 1; id_rs = 5; id_uses_rs = 1;
            if (i == 2) begin wb_valid = 1; wb_dst = 5; end
            #1;
            tests++; if (stall !== 1'b1 || issue !== 1'b0)
                begin fails++; $display("FAIL raw_stall_c%0d got stall=%b issue=%b exp stall=1 issue=0", i, stall, issue); end
            tick();
            exp_sc++;
        end
        clr_inputs();
        id_valid = 1; id_rs = 5; id_uses_rs = 1;
        #1;
        tests++; if (stall !== 1'b0 || issue !== 1'b1)
            begin fails++; $display("FAIL raw_release got stall=%b issue=%b exp stall=0 issue=1", stall, issue); end
        tests++; if (busy_mask !== 32'h0) begin fails++; $display("FAIL raw_busy got=%h exp=0", busy_mask); end
        tests++; if (stall_count !== 32'd3) begin fails++; $display("FAIL raw_stall_count got=%0d exp=3", stall_count); end
        tick();
        clr_inputs();
    endtask

    task automatic test_rt_hazard();
        drive_writer(12);
        tick();
        clr_inputs();
        id_valid = 1; id_rt = 12; id_rs = 12; id_uses_rt = 0; id_uses_rs = 0;
        #1;
        tests++; if (stall !== 1'b0) begin fails++; $display("FAIL rt_unused_stall got=%b exp=0", stall); end
        id_uses_rt = 1;
        #1;
        tests++; if (stall !== 1'b1) begin fails++; $display("FAIL rt_used_stall got=%b exp=1", stall); end
        tick();
        exp_sc++;
        drive_wb(12);
        tick();
        clr_inputs();
        #1;
        tests++; if (busy_mask !== 32'h0) begin fails++; $display("FAIL rt_busy_clear got=%h exp=0", busy_mask); end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 3; i++) begin
            drive_writer(8);
            tests++; if (issue !== 1'b1) begin fails++; $display("FAIL sat_issue_%0d got=%b exp=1", i, issue); end
            tick();
        end
        drive_writer(8);
        tests++; if (stall !== 1'b1 || issue !== 1'b0)
            begin fails++; $display("FAIL sat_fourth got stall=%b issue=%b exp stall=1 issue=0", stall, issue); end
        tick();
        exp_sc++;
        for (int i = 0; i < 3; i++) begin
            drive_wb(8);
            tick();
            tests++; if (busy_mask[8] !== (i < 2))
                begin fails++; $display("FAIL sat_wb_%0d busy8 got=%b exp=%b", i, busy_mask[8], (i < 2)); end
        end
        clr_inputs();
        tests++; if (stall_count !== 32'(exp_sc))
            begin fails++; $display("FAIL sat_stall_count got=%0d exp=%0d", stall_count, exp_sc); end
    endtask

    task automatic test_same_cycle();
        drive_writer(9);
        tick();
        drive_writer(9);
        wb_valid = 1; wb_dst = 9;
        #1;
        tests++; if (issue !== 1'b1) begin fails++; $display("FAIL same_issue got=%b exp=1", issue); end
        tick();
        clr_inputs();
        #1;
        tests++; if (busy_mask[9] !== 1'b1) begin fails++; $display("FAIL same_busy9 got=%b exp=1", busy_mask[9]); end
        drive_wb(9);
        tick();
        clr_inputs();
        tests++; if (busy_mask[9] !== 1'b0 || underflow !== 1'b0)
            begin fails++; $display("FAIL same_drain got busy9=%b uf=%b exp busy9=0 uf=0", busy_mask[9], underflow); end
    endtask

    task automatic test_r0();
        clr_inputs();
        id_valid = 1; id_uses_rs = 1; id_uses_rt = 1; id_writes = 1;
        #1;
        tests++; if (stall !== 1'b0 || issue !== 1'b1)
            begin fails++; $display("FAIL r0_issue got stall=%b issue=%b exp stall=0 issue=1", stall, issue); end
        tick();
        tests++; if (busy_mask !== 32'h0) begin fails++; $display("FAIL r0_busy got=%h exp=0", busy_mask); end
        tests++; if (stall !== 1'b0) begin fails++; $display("FAIL r0_read_stall got=%b exp=0", stall); end
        tick();
        clr_inputs();
        wb_valid = 1; kill_valid = 1;
        tick();
        clr_inputs();
        tests++; if (underflow !== 1'b0 || busy_mask !== 32'h0)
            begin fails++; $display("FAIL r0_retire got uf=%b busy=%h exp uf=0 busy=0", underflow, busy_mask); end
        exp_sc = exp_sc;
    endtask

    task automatic test_kill_underflow();
        drive_writer(31);
        tick();
        clr_inputs();
        tests++; if (busy_mask[31] !== 1'b1) begin fails++; $display("FAIL kill_busy31_set got=%b exp=1", busy_mask[31]); end
        kill_valid = 1; kill_dst = 31;
        tick();
        clr_inputs();
        tests++; if (busy_mask[31] !== 1'b0 || underflow !== 1'b0)
            begin fails++; $display("FAIL kill_clear got busy31=%b uf=%b exp busy31=0 uf=0", busy_mask[31], underflow); end
        drive_wb(31);
        tick();
        clr_inputs();
        tests++; if (underflow !== 1'b1 || busy_mask !== 32'h0)
            begin fails++; $display("FAIL extra_wb got uf=%b busy=%h exp uf=1 busy=0", underflow, busy_mask); end
        tick(); tick();
        tests++; if (underflow !== 1'b1) begin fails++; $display("FAIL uf_sticky got=%b exp=1", underflow); end
    endtask

    task automatic test_reset_midflight();
        drive_writer(4);
        tick();
        clr_inputs();
        id_valid = 1; id_rs = 4; id_uses_rs = 1;
        #1;
        tests++; if (stall !== 1'b1) begin fails++; $display("FAIL mid_stall got=%b exp=1", stall); end
        tick();
        exp_sc++;
        tests++; if (stall_count !== 32'(exp_sc))
            begin fails++; $display("FAIL mid_stall_count got=%0d exp=%0d", stall_count, exp_sc); end
        clr_inputs();
        reset = 1;
        tick();
        reset = 0;
        #1;
        tests++; if (busy_mask !== 32'h0 || stall_count !== 32'd0 || underflow !== 1'b0)
            begin fails++; $display("FAIL mid_reset got busy=%h sc=%0d uf=%b exp busy=0 sc=0 uf=0", busy_mask, stall_count, underflow); end
        id_valid = 1; id_rs = 4; id_uses_rs = 1;
        #1;
        tests++; if (stall !== 1'b0) begin fails++; $display("FAIL mid_after_stall got=%b exp=0", stall); end
        clr_inputs();
    endtask

    initial begin
        tests = 0; fails = 0; exp_sc = 0;
        reset = 1;
        clr_inputs();
        test_reset();
        test_basic_issue();
        test_raw_hazard();
        test_rt_hazard();
        test_saturation();
        test_same_cycle();
        test_r0();
        test_kill_underflow();
        test_reset_midflight();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1);
    end

endmodule
